// File: rtl/fpu_arb_pkg.sv
// Shared types for the two-requester FPU operation scheduler.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fpu_arb_pkg;

  // Default operand/result width of the shared datapath.
  localparam int DATA_W_DEF = 32;

  // Opcode carried on req0_op / req1_op.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Scheduler states; exactly one operation is in flight outside IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXEC     = 2'b01,
    DIV_WAIT = 2'b10,
    RESP     = 2'b11
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: lone requester wins, contention goes to the one not granted last.
// Latency: grant is combinational from req and the registered last-grant pointer.
// Backpressure: pointer only moves when the caller signals the grant was accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // Index of the requester granted most recently; reset to 1 so requester 0 wins first.
  logic last_gnt;

  // One-hot grant from the current requests and the last-grant pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who won, but only once the grant has actually been consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (accept) begin
      last_gnt <= gnt[1];
    end
  end

endmodule

// File: rtl/fpu_arb_sched.sv
// Arbitrates two requesters onto a shared add/mul/div datapath, one operation at a time.
// Latency: add/mul/error respond 2 cycles after the request handshake; div waits for div_complete.
// Backpressure: response held until rsp_ready; no request is accepted until the response drains.
// Build option: define FPU_ARB_DIV_TIMEOUT_EN to abort a divide after DIV_TIMEOUT cycles with rsp_err.
module fpu_arb_sched
  import fpu_arb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req0_op,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              div_start,
  input  logic              div_complete,
  input  logic [DATA_W-1:0] add_result,
  input  logic [DATA_W-1:0] mul_result,
  input  logic [DATA_W-1:0] div_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  // A zero timeout would make every divide fail immediately; reject it at elaboration.
  if (DIV_TIMEOUT < 1) begin : g_tmo_param_chk
    $error("fpu_arb_sched: DIV_TIMEOUT must be at least 1");
  end

  state_e            state;
  op_e               op_q;
  logic [1:0]        gnt;
  logic              req_hs;
  logic              sel;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              tmo_hit;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .accept (req_hs),
    .gnt    (gnt)
  );

  // Ready only toward the granted requester while idle; held low through the reset cycle.
  assign req_ready = (state == IDLE && !rst) ? gnt : 2'b00;
  assign req_hs    = |(req_valid & req_ready);

  // Payload mux follows the grant so the latched operands always belong to the winner.
  assign sel    = gnt[1];
  assign sel_op = sel ? req1_op : req0_op;
  assign sel_a  = sel ? req1_a  : req0_a;
  assign sel_b  = sel ? req1_b  : req0_b;

`ifdef FPU_ARB_DIV_TIMEOUT_EN
  localparam int TMO_W = $clog2(DIV_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Fires on the last allowed DIV_WAIT cycle so the error response lands exactly DIV_TIMEOUT cycles in.
  assign tmo_hit = (state == DIV_WAIT) && (tmo_cnt == TMO_W'(DIV_TIMEOUT - 1));

  // Cycles spent in DIV_WAIT; zeroed in EXEC so each divide starts its budget fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == EXEC) begin
      tmo_cnt <= '0;
    end else if (state == DIV_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  // Without the timeout option a divide waits for div_complete indefinitely.
  assign tmo_hit = 1'b0;
`endif

  // Scheduler FSM with all datapath-facing and response outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      alu_a     <= '0;
      alu_b     <= '0;
      div_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            op_q   <= op_e'(sel_op);
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            rsp_id <= sel;
            // Decide the start pulse here so it is a clean registered pulse during EXEC.
            div_start <= (op_e'(sel_op) == OP_DIV) && (sel_b != '0);
            state  <= EXEC;
          end
        end

        EXEC: begin
          div_start <= 1'b0;
          case (op_q)
            OP_ADD: begin
              rsp_data  <= add_result;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
            OP_MUL: begin
              rsp_data  <= mul_result;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
            OP_DIV: begin
              if (alu_b != '0) begin
                state <= DIV_WAIT;
              end else begin
                // Divide by zero never reaches the divider.
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
            end
            OP_RSVD: begin
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          endcase
        end

        DIV_WAIT: begin
          // Completion wins over a timeout landing in the same cycle.
          if (div_complete) begin
            rsp_data  <= div_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (tmo_hit) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arb_sched.sv
// Randomized plus directed bench for fpu_arb_sched against a transaction-level reference model.
// Latency: expects add/mul/error responses 2 cycles after handshake, divides after the stub delay.
// Backpressure: stalls rsp_ready for random stretches and checks the response stays frozen.
module tb_fpu_arb_sched;

  localparam int DW  = 32;
  localparam int TMO = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [DW-1:0] alu_a, alu_b;
  logic          div_start;
  logic          div_complete;
  logic [DW-1:0] add_result, mul_result, div_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  fpu_arb_sched #(.DATA_W(DW), .DIV_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_op      (req0_op),
    .req1_op      (req1_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .div_start    (div_start),
    .div_complete (div_complete),
    .add_result   (add_result),
    .mul_result   (mul_result),
    .div_result   (div_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  // Adder and multiplier stubs compute from whatever the scheduler drives on alu_a/alu_b.
  assign add_result = alu_a + alu_b;
  assign mul_result = alu_a * alu_b;

  int n_chk = 0;
  int n_err = 0;
  int n_div_start = 0;

  always @(negedge clk) if (div_start === 1'b1) n_div_start++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending requests per requester, last winner, and the value the divider stub returns.
  bit [1:0]      pend;
  logic [1:0]    p_op [2];
  logic [DW-1:0] p_a  [2];
  logic [DW-1:0] p_b  [2];
  int            mdl_last;
  logic [DW-1:0] div_stub;
  logic          last_id;
  logic [DW-1:0] last_data;

  function automatic int mdl_grant(input bit [1:0] v);
    if (v == 2'b11) return 1 - mdl_last;
    if (v[1]) return 1;
    return 0;
  endfunction

  task automatic mdl_result(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            output logic [DW-1:0] d, output logic e, output bit is_div);
    is_div = 1'b0;
    case (op)
      2'd0: begin d = a + b; e = 1'b0; end
      2'd1: begin d = a * b; e = 1'b0; end
      2'd2: begin
        if (b == 0) begin d = '0; e = 1'b1; end
        else begin d = div_stub; e = 1'b0; is_div = 1'b1; end
      end
      default: begin d = '0; e = 1'b1; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    req_valid = pend;
    req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
    req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    pend[i] = 1'b1; p_op[i] = op; p_a[i] = a; p_b[i] = b;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0; div_complete = 1'b0;
    tick();
    #1;
    chk({tag, ".rst_ready"}, req_ready, 2'b00);
    chk({tag, ".rst_valid"}, rsp_valid, 0);
    chk({tag, ".rst_err"}, rsp_err, 0);
    chk({tag, ".rst_data"}, rsp_data, 0);
    chk({tag, ".rst_id"}, rsp_id, 0);
    chk({tag, ".rst_dstart"}, div_start, 0);
    chk({tag, ".rst_alu_a"}, alu_a, 0);
    chk({tag, ".rst_alu_b"}, alu_b, 0);
    rst = 1'b0; req_valid = 2'b00;
    mdl_last = 1;
  endtask

  // One complete transaction from IDLE: grant, execute, optional divide, stalled response, drain.
  // div_delay < 0 means the divider never completes (timeout build only).
  task automatic do_txn(input string tag, input int div_delay, input int hold);
    int g;
    logic [DW-1:0] ea, eb, ed;
    logic ee;
    bit dv;
    int k;
    drive_reqs();
    #1;
    g = mdl_grant(pend);
    chk({tag, ".grant"}, req_ready, (g == 1) ? 2'b10 : 2'b01);
    if ((req_valid & req_ready) == 2'b00) begin
      do_reset({tag, ".recover"});
      return;
    end
    ea = p_a[g]; eb = p_b[g];
    mdl_result(p_op[g], ea, eb, ed, ee, dv);
    if (div_delay < 0 && dv) begin ed = '0; ee = 1'b1; end
    mdl_last = g;
    pend[g] = 1'b0;
    tick();
    drive_reqs();
    #1;
    chk({tag, ".exec_ready"}, req_ready, 2'b00);
    chk({tag, ".alu_a"}, alu_a, ea);
    chk({tag, ".alu_b"}, alu_b, eb);
    chk({tag, ".div_start"}, div_start, dv);
    chk({tag, ".exec_valid"}, rsp_valid, 0);
    if (dv && div_delay >= 0) begin
      for (int i = 1; i <= div_delay; i++) begin
        tick();
        #1;
        chk({tag, ".dstart_once"}, div_start, 0);
        chk({tag, ".wait_valid"}, rsp_valid, 0);
        chk({tag, ".alu_hold"}, {alu_a, alu_b}, {ea, eb});
      end
      div_complete = 1'b1; div_result = div_stub;
      tick();
      div_complete = 1'b0; div_result = $urandom;
      #1;
    end else if (dv) begin
      k = 0;
      while (rsp_valid !== 1'b1 && k < TMO + 8) begin
        tick();
        #1;
        k++;
      end
      chk({tag, ".tmo_cycles"}, k - 1, TMO);
    end else begin
      tick();
      #1;
    end
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_id"}, rsp_id, g);
    chk({tag, ".rsp_data"}, rsp_data, ed);
    chk({tag, ".rsp_err"}, rsp_err, ee);
    last_id = rsp_id;
    last_data = rsp_data;
    for (int i = 0; i < hold; i++) begin
      if ($urandom_range(0, 2) == 0) begin div_complete = 1'b1; div_result = $urandom; end
      tick();
      div_complete = 1'b0;
      #1;
      chk({tag, ".hold_valid"}, rsp_valid, 1);
      chk({tag, ".hold_data"}, {rsp_id, rsp_err, rsp_data}, {g[0], ee, ed});
      chk({tag, ".hold_ready"}, req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk({tag, ".drained"}, rsp_valid, 0);
  endtask

  task automatic rand_fill();
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(0, 1) == 1)
        set_req(i, 2'($urandom_range(0, 3)), $urandom,
                ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom));
    end
    if (pend == 2'b00) set_req(0, 2'($urandom_range(0, 3)), $urandom, $urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ds0;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0; div_complete = 1'b0;
    div_result = '0; div_stub = '0; pend = 2'b00;
    for (int i = 0; i < 2; i++) begin p_op[i] = 2'd0; p_a[i] = '0; p_b[i] = '0; end
    drive_reqs();
    mdl_last = 1;
    do_reset("por");

    // Both requesters contend for four back-to-back operations; winners must alternate from 0.
    set_req(0, 2'd0, $urandom, $urandom);
    set_req(1, 2'd1, $urandom, $urandom);
    for (int i = 0; i < 4; i++) begin
      do_txn("alt", 0, 0);
      chk("alt.order", last_id, i % 2);
      if (!pend[0]) set_req(0, 2'($urandom_range(0, 1)), $urandom, $urandom);
      if (!pend[1]) set_req(1, 2'($urandom_range(0, 1)), $urandom, $urandom);
    end
    pend = 2'b00;

    // Single add with a five-cycle response stall.
    set_req(0, 2'd0, 32'h0080_0000, 32'h0080_0000);
    do_txn("add", 0, 5);
    chk("add.literal", last_data, 32'h0100_0000);

    // Divide from requester 1 completing 20 cycles after the start pulse.
    ds0 = n_div_start;
    div_stub = 32'h0200_0000;
    set_req(1, 2'd2, $urandom, 32'h0040_0000);
    do_txn("div", 20, 1);
    chk("div.literal", last_data, 32'h0200_0000);
    chk("div.pulses", n_div_start - ds0, 1);

    // Divide by zero and reserved opcode both fail without touching the divider.
    ds0 = n_div_start;
    set_req(0, 2'd3, $urandom, $urandom);
    set_req(1, 2'd2, $urandom, '0);
    do_txn("err0", 0, 1);
    do_txn("err1", 0, 0);
    chk("err.no_dstart", n_div_start - ds0, 0);

`ifdef FPU_ARB_DIV_TIMEOUT_EN
    set_req(0, 2'd2, $urandom, 32'h0000_0003);
    do_txn("tmo", -1, 2);
`endif

    // Reset while waiting on the divider, then a stale completion must be ignored.
    pend = 2'b10; p_op[1] = 2'd2; p_a[1] = $urandom; p_b[1] = 32'h0040_0000;
    drive_reqs();
    #1;
    chk("abort.grant", req_ready, 2'b10);
    tick();
    pend = 2'b00;
    drive_reqs();
    #1;
    chk("abort.dstart", div_start, 1);
    tick();
    tick();
    do_reset("abort");
    div_complete = 1'b1; div_result = $urandom;
    tick();
    div_complete = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("abort.no_rsp", {rsp_valid, rsp_err, div_start, rsp_id}, 4'b0000);
      chk("abort.quiet", {rsp_data, alu_a}, 64'h0);
      tick();
    end
    set_req(0, 2'd0, $urandom, $urandom);
    set_req(1, 2'd1, $urandom, $urandom);
    do_txn("rst_ptr", 0, 0);
    chk("rst_ptr.first", last_id, 0);

    // Randomized traffic mix.
    for (int n = 0; n < 40; n++) begin
      rand_fill();
      div_stub = $urandom;
      do_txn("rnd", $urandom_range(1, 12), $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fpu_arb_sched.md
FPU_ARB_SCHED -- requirements
Module: fpu_arb_sched

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter DIV_TIMEOUT, default 64, max cycles waiting for divider completion.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid[1:0], req_ready[1:0]  input/output  2 each  per-requester valid/ready handshake.
REQ-006 req0_op, req1_op  input  2  opcode: 00 add, 01 mul, 10 div, 11 reserved.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  DATA_W  operands.
REQ-008 alu_a, alu_b  output  DATA_W  registered operands driven to shared adder/multiplier/divider.
REQ-009 div_start  output  1  one-cycle divider start pulse; div_complete  input  1  divider done.
REQ-010 add_result, mul_result, div_result  input  DATA_W  datapath results.
REQ-011 rsp_valid output 1, rsp_ready input 1, rsp_id output 1 (requester index), rsp_data output DATA_W, rsp_err output 1.

Function
REQ-012 FSM states IDLE, EXEC, DIV_WAIT, RESP; one operation in flight at a time.
REQ-013 req_ready[i] high only in IDLE and only for the granted requester; grant combinational from req_valid and rr pointer.
REQ-014 Round-robin: single valid requester always granted; both valid -> grant the one not granted last; pointer updates only on accepted handshake.
REQ-015 On handshake in IDLE: latch op, operands (into alu_a/alu_b) and id; go EXEC next cycle.
REQ-016 EXEC, add/mul: capture add_result/mul_result into rsp_data, rsp_err=0, go RESP; rsp_valid asserts 2 cycles after handshake.
REQ-017 EXEC, div with alu_b nonzero: assert div_start this cycle only, go DIV_WAIT.
REQ-018 EXEC, div with alu_b==0 or op 11: no div_start, rsp_data=0, rsp_err=1, go RESP.
REQ-019 DIV_WAIT: on div_complete capture div_result, rsp_err=0, go RESP; div_complete seen in any other state ignored.
REQ-020 RESP: rsp_valid held with rsp_id/rsp_data/rsp_err stable until rsp_ready; on rsp_valid&&rsp_ready go IDLE; new request accepted earliest the following cycle.
REQ-021 alu_a/alu_b hold stable from EXEC through end of DIV_WAIT.

Reset
REQ-022 On rst: state IDLE, rr pointer favours requester 0, req_ready=0 during reset cycle, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_id=0, div_start=0, alu_a=alu_b=0, timeout counter 0.
REQ-023 rst mid-operation (EXEC/DIV_WAIT/RESP) aborts it with no response; stale later div_complete ignored.

Configuration
REQ-024 Macro FPU_ARB_DIV_TIMEOUT_EN defined: counter runs in DIV_WAIT; after DIV_TIMEOUT cycles without div_complete, rsp_data=0, rsp_err=1, go RESP; counter clears on entering DIV_WAIT.
REQ-025 Macro undefined: no counter logic; DIV_WAIT waits indefinitely; DIV_TIMEOUT unused.

Structure
REQ-026 Package fpu_arb_pkg holds opcode enum (OP_ADD, OP_MUL, OP_DIV, OP_RSVD), FSM state enum, DATA_W default constant.
REQ-027 Sub-module rr_arb2 (2-way round-robin, pointer update on accept) instantiated once.

Verification
REQ-028 req0 add a=32'h0080_0000 b=32'h0080_0000, stub add_result=32'h0100_0000 -> rsp_valid at handshake+2, rsp_id=0, rsp_data=32'h0100_0000, rsp_err=0.
REQ-029 req0 and req1 valid same cycle for 4 consecutive ops -> grants alternate 0,1,0,1; first after reset is 0.
REQ-030 req1 div b=32'h0040_0000, div_complete 20 cycles after div_start, div_result=32'h0200_0000 -> single div_start pulse, rsp_id=1, rsp_data=32'h0200_0000.
REQ-031 div with b=0 and op 11 -> no div_start, rsp_err=1, rsp_data=0.
REQ-032 rsp_ready low 5 cycles -> rsp_valid/data stable, req_ready stays 0; with FPU_ARB_DIV_TIMEOUT_EN and no div_complete -> rsp_err=1 exactly DIV_TIMEOUT cycles after entering DIV_WAIT.
REQ-033 rst asserted in DIV_WAIT, then div_complete pulsed -> no rsp_valid, all outputs at reset values.
